// File: rtl/vga_pkg.sv
// Shared VGA definitions used by the pixel stream stage and the timing
// generator: default active-area geometry, the packed RGB pixel type, the
// FIFO entry layout and the stream state encoding.
package vga_pkg;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int V_ACTIVE_DEFAULT = 480;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // One buffered beat: start-of-frame marker plus the pixel itself.
  typedef struct packed {
    logic sof;
    rgb_t rgb;
  } pix_entry_t;

  localparam int ENTRY_W = $bits(pix_entry_t);

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2
  } stream_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO for buffered pixel entries.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   flush       synchronous clear of all entries (wins over wr_en/rd_en)
//   wr_en       write wr_data when not full
//   rd_en       pop the head entry when not empty
//   rd_data     current head entry (valid when !empty)
//   full/empty  occupancy flags
//   level       current occupancy, 0..DEPTH
// A beat written in cycle N becomes visible at the head in cycle N+1;
// there is no write-to-read bypass.
module pixel_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rd_data = mem[rd_ptr];

  assign do_wr = wr_en && !full && !flush;
  assign do_rd = rd_en && !empty && !flush;

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_pixel_stream.sv
// Pixel streaming stage in front of the VGA DACs. Buffers renderer pixels,
// releases one per display-enable cycle and keeps the stream aligned to
// frame boundaries using start-of-frame markers.
// Ports:
//   clk, rst            pixel clock, asynchronous active-low reset
//   s_valid/s_ready     renderer handshake, s_data = {R,G,B}, s_sof marks
//                       the first pixel of a frame
//   frame_start         timing generator pulse, one cycle before first pixel
//   de                  display enable, one pixel per high cycle
//   Red/Green/Blue      registered DAC outputs, black when nothing popped
//   underflow/sync_err  sticky error flags, cleared by frame_start in ARMED
//   fifo_level          FIFO occupancy
//
// state  | meaning
// RESYNC | FIFO flushed, dropping beats until a start-of-frame beat arrives
// ARMED  | frame head buffered, waiting for frame_start
// STREAM | popping one pixel per de cycle until the frame is complete
module vga_pixel_stream
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int H_ACTIVE   = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE   = V_ACTIVE_DEFAULT,
  parameter int LW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [23:0]   s_data,
  input  logic          s_sof,
  input  logic          frame_start,
  input  logic          de,
  output logic [7:0]    Red,
  output logic [7:0]    Green,
  output logic [7:0]    Blue,
  output logic          underflow,
  output logic          sync_err,
  output logic [LW-1:0] fifo_level
);

  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam int CW        = $clog2(FRAME_PIX + 1);

  stream_state_t state;
  stream_state_t state_nxt;

  logic [CW-1:0]      pix_cnt;
  logic [ENTRY_W-1:0] fifo_rd_data;
  pix_entry_t         head;
  pix_entry_t         wr_entry;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_flush;
  logic               push;
  logic               pop;
  logic               ready_raw;
  logic               set_uf;
  logic               set_se;
  logic               clr_flags;
  logic               cnt_clr;
  logic               cnt_inc;
  logic               rgb_load;
  rgb_t               rgb_q;

  assign head     = fifo_rd_data;
  assign wr_entry = {s_sof, s_data};

  // Gating with rst keeps s_ready low throughout reset while still letting
  // it rise in the very first cycle after release.
  assign s_ready = rst && ready_raw;

  // In RESYNC only start-of-frame beats are kept; the rest are accepted
  // and dropped so the renderer can skip ahead to the next frame.
  assign push = s_valid && s_ready && ((state != RESYNC) || s_sof);

  // Flush on the transition into RESYNC so the state starts with an empty
  // FIFO; anything accepted in that same cycle is intentionally discarded.
  assign fifo_flush = (state_nxt == RESYNC) && (state != RESYNC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RESYNC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready_raw = 1'b0;
    pop       = 1'b0;
    set_uf    = 1'b0;
    set_se    = 1'b0;
    clr_flags = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    rgb_load  = 1'b0;
    case (state)
      RESYNC: begin
        ready_raw = 1'b1;
        if (s_valid && s_sof) begin
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        ready_raw = !fifo_full;
        if (frame_start) begin
          clr_flags = 1'b1;
        end
        if (!fifo_empty && !head.sof) begin
          set_se    = 1'b1;
          state_nxt = RESYNC;
        end else if (frame_start) begin
          cnt_clr   = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        ready_raw = !fifo_full;
        if (frame_start) begin
          set_se    = 1'b1;
          state_nxt = RESYNC;
        end else if (de) begin
          if (fifo_empty) begin
            set_uf    = 1'b1;
            state_nxt = RESYNC;
          end else begin
            pop = 1'b1;
            if (head.sof && (pix_cnt != '0)) begin
              // A new frame began early; show black rather than a pixel
              // from the wrong frame.
              set_se    = 1'b1;
              state_nxt = RESYNC;
            end else begin
              rgb_load = 1'b1;
              cnt_inc  = 1'b1;
              if (pix_cnt == CW'(FRAME_PIX - 1)) begin
                state_nxt = ARMED;
              end
            end
          end
        end
      end
      default: begin
        state_nxt = RESYNC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt <= '0;
    end else if (cnt_clr) begin
      pix_cnt <= '0;
    end else if (cnt_inc) begin
      pix_cnt <= pix_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q <= '0;
    end else if (rgb_load) begin
      rgb_q <= head.rgb;
    end else begin
      rgb_q <= '0;
    end
  end

  // Setting wins over clearing so an error in the clearing cycle is kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underflow <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      if (set_uf) begin
        underflow <= 1'b1;
      end else if (clr_flags) begin
        underflow <= 1'b0;
      end
      if (set_se) begin
        sync_err <= 1'b1;
      end else if (clr_flags) begin
        sync_err <= 1'b0;
      end
    end
  end

  assign Red   = rgb_q.r;
  assign Green = rgb_q.g;
  assign Blue  = rgb_q.b;

  pixel_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (fifo_flush),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

endmodule

// File: tb/tb_vga_pixel_stream.sv
module tb_vga_pixel_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        s_sof;
  logic        frame_start;
  logic        de;
  logic [7:0]  Red;
  logic [7:0]  Green;
  logic [7:0]  Blue;
  logic        underflow;
  logic        sync_err;
  logic [2:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  logic [24:0] feed_q[$];
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  vga_pixel_stream #(
    .FIFO_DEPTH (4),
    .H_ACTIVE   (4),
    .V_ACTIVE   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_sof       (s_sof),
    .frame_start (frame_start),
    .de          (de),
    .Red         (Red),
    .Green       (Green),
    .Blue        (Blue),
    .underflow   (underflow),
    .sync_err    (sync_err),
    .fifo_level  (fifo_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: drive de/frame_start and the next renderer beat,
  // check the RGB expected from the previous cycle at the falling edge,
  // then queue this cycle's expected RGB for the next call.
  task automatic step(input logic de_v, input logic fs_v, input logic [23:0] exp_v);
    logic        acc;
    logic [23:0] e;
    de          = de_v;
    frame_start = fs_v;
    if (feed_q.size() > 0) begin
      s_valid = 1'b1;
      {s_sof, s_data} = feed_q[0];
    end else begin
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_data  = '0;
    end
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rgb", 32'({Red, Green, Blue}), 32'(e));
    end
    acc = s_valid && s_ready;
    @(posedge clk);
    #1;
    if (acc) void'(feed_q.pop_front());
    exp_q.push_back(exp_v);
    de          = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    s_sof = 1'b0;
    frame_start = 1'b0;
    de = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_rgb", 32'({Red, Green, Blue}), 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_ready", 32'(s_ready), 32'd1);
    chk("rel_level", 32'(fifo_level), 32'd0);
    chk("rel_uf", 32'(underflow), 32'd0);
    chk("rel_se", 32'(sync_err), 32'd0);
    @(posedge clk);
    #1;
    idle(2);

    // Normal frame: pixels 1..8, de 4 high / 2 low / 4 high
    for (int i = 1; i <= 8; i++) feed_q.push_back({(i == 1), 24'(i)});
    idle(6);
    chk("n_level_full", 32'(fifo_level), 32'd4);
    step(1'b0, 1'b1, 24'h0);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 24'(i));
    idle(2);
    for (int i = 5; i <= 8; i++) step(1'b1, 1'b0, 24'(i));
    idle(2);
    chk("n_uf", 32'(underflow), 32'd0);
    chk("n_se", 32'(sync_err), 32'd0);
    chk("n_level_end", 32'(fifo_level), 32'd0);

    // Underflow: renderer stalls after 5 pixels
    for (int i = 0; i < 5; i++) feed_q.push_back({(i == 0), 24'(32'h10 + i)});
    idle(6);
    step(1'b0, 1'b1, 24'h0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 24'(32'h10 + i));
    step(1'b1, 1'b0, 24'h0);
    chk("u_flag", 32'(underflow), 32'd1);
    chk("u_level", 32'(fifo_level), 32'd0);
    chk("u_ready", 32'(s_ready), 32'd1);

    // Resync drop: three non-sof beats discarded, sof beat kept
    feed_q.push_back({1'b0, 24'h000021});
    feed_q.push_back({1'b0, 24'h000022});
    feed_q.push_back({1'b0, 24'h000023});
    feed_q.push_back({1'b1, 24'hFF0000});
    idle(5);
    chk("d_level", 32'(fifo_level), 32'd1);
    chk("d_uf_sticky", 32'(underflow), 32'd1);
    for (int i = 2; i <= 8; i++) feed_q.push_back({1'b0, 24'(32'h100 + i)});
    idle(4);
    step(1'b0, 1'b1, 24'h0);
    chk("d_uf_clear", 32'(underflow), 32'd0);
    step(1'b1, 1'b0, 24'hFF0000);
    for (int i = 2; i <= 8; i++) step(1'b1, 1'b0, 24'(32'h100 + i));
    idle(1);
    chk("d_se", 32'(sync_err), 32'd0);

    // Misplaced sof on pixel 3
    for (int i = 1; i <= 8; i++) feed_q.push_back({(i == 1 || i == 3), 24'(32'h30 + i)});
    idle(6);
    step(1'b0, 1'b1, 24'h0);
    step(1'b1, 1'b0, 24'h000031);
    step(1'b1, 1'b0, 24'h000032);
    step(1'b1, 1'b0, 24'h0);
    chk("s_flag", 32'(sync_err), 32'd1);
    chk("s_level", 32'(fifo_level), 32'd0);
    idle(3);
    chk("s_drop_level", 32'(fifo_level), 32'd0);
    for (int i = 1; i <= 8; i++) feed_q.push_back({(i == 1), 24'(32'h40 + i)});
    idle(5);
    chk("s_se_sticky", 32'(sync_err), 32'd1);
    step(1'b0, 1'b1, 24'h0);
    chk("s_se_clear", 32'(sync_err), 32'd0);
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 24'(32'h40 + i));
    idle(1);
    chk("s_recover_se", 32'(sync_err), 32'd0);

    // Reset mid-frame with three entries buffered
    for (int i = 1; i <= 4; i++) feed_q.push_back({(i == 1), 24'(32'h50 + i)});
    idle(5);
    step(1'b0, 1'b1, 24'h0);
    step(1'b1, 1'b0, 24'h000051);
    chk("r_level_pre", 32'(fifo_level), 32'd3);
    chk("r_rgb_pre", 32'({Red, Green, Blue}), 32'h000051);
    rst = 1'b0;
    #1;
    chk("r_rgb", 32'({Red, Green, Blue}), 32'd0);
    chk("r_level", 32'(fifo_level), 32'd0);
    chk("r_ready_low", 32'(s_ready), 32'd0);
    exp_q.delete();
    feed_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("r_ready_rel", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    feed_q.push_back({1'b0, 24'h000060});
    idle(2);
    chk("r_nosof_drop", 32'(fifo_level), 32'd0);
    feed_q.push_back({1'b1, 24'h000061});
    idle(2);
    chk("r_sof_keep", 32'(fifo_level), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_pixel_stream.md
# vga_pixel_stream

Pixel streaming stage directly upstream of the VGA controller. It accepts an RGB pixel stream from the renderer over a valid/ready handshake and buffers it in a small FIFO. It releases one pixel per pixel clock while the timing generator asserts display-enable, and drives the 8-bit Red/Green/Blue DAC outputs. It re-aligns to frame boundaries on start-of-frame markers and reports underflow and sync errors.

## Interface
Parameters:
- FIFO_DEPTH, 16, buffered pixels (power of two, ≥4)
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame

Ports:
- clk  in  1  pixel clock (25 MHz, same clock as VGA_clk)
- rst  in  1  reset, asynchronous, active-low
- s_valid  in  1  renderer pixel valid
- s_ready  out  1  stage can accept a beat
- s_data  in  24  pixel {R[23:16], G[15:8], B[7:0]}
- s_sof  in  1  beat is first pixel of a frame
- frame_start  in  1  one-cycle pulse from timing generator, one cycle before first active pixel of a frame
- de  in  1  display enable, high for each active pixel
- Red  out  8  DAC red
- Green  out  8  DAC green
- Blue  out  8  DAC blue
- underflow  out  1  sticky, FIFO empty while de in STREAM
- sync_err  out  1  sticky, frame misalignment detected
- fifo_level  out  $clog2(FIFO_DEPTH+1)  current occupancy

## Operation
- FIFO entries are 25 bits: {sof, rgb}. A write occurs on s_valid && s_ready.
- States: RESYNC, ARMED, STREAM. Reset enters RESYNC.
- RESYNC:
  - FIFO flushed on entry; s_ready=1.
  - Beats with s_sof=0 are discarded.
  - The first s_sof=1 beat is written to the FIFO, then the FSM moves to ARMED.
- ARMED:
  - s_ready = !full.
  - On frame_start, pixel counter cleared and FSM moves to STREAM.
  - If the FIFO head has sof=0, sync_err is set and the FSM goes to RESYNC.
- STREAM:
  - Each cycle with de=1 and FIFO non-empty pops one entry.
  - RGB is registered from the popped entry and the pixel counter increments.
  - Popped entry with sof=1 while counter≠0: set sync_err, go to RESYNC.
  - After pop number H_ACTIVE*V_ACTIVE, go to ARMED.
  - de=1 with FIFO empty: output black, set underflow, go to RESYNC.
  - frame_start before the frame completes: set sync_err, go to RESYNC.
- Red/Green/Blue are 0 whenever no pop occurred in the previous cycle.
- underflow and sync_err clear on the first frame_start seen in ARMED.
- Pixel counter width is $clog2(H_ACTIVE*V_ACTIVE+1) and does not wrap inside a frame.

## Timing
- Reset values: Red=Green=Blue=0, underflow=0, sync_err=0, fifo_level=0, state RESYNC. s_ready=0 while rst is asserted and 1 in the first cycle after release.
- Latency is 1 cycle from de=1 to valid RGB. The timing generator delays Hsync/Vsync by one cycle to match.
- s_ready is a pure function of state and occupancy; it never depends on s_valid.
- Write-to-read latency is 1 cycle. A beat written in cycle N is poppable in cycle N+1; there is no bypass, so write+pop on an empty FIFO is an underflow.
- When full, s_ready=0 even if a pop occurs the same cycle.
- Simultaneous pop and write at non-full occupancy leaves fifo_level unchanged.
- Reset mid-frame:
  - Immediate return to reset values.
  - FIFO contents discarded.
  - The next frame needs a fresh s_sof.

## Structure
- Shared package vga_pkg holds:
  - H_ACTIVE/V_ACTIVE defaults (640/480)
  - packed rgb_t {r,g,b}
  - stream state enum {RESYNC, ARMED, STREAM}
- The timing generator imports the same constants.
- One sub-module, pixel_fifo: a synchronous FIFO of width 25 and depth FIFO_DEPTH with full/empty/level outputs and a sync flush input. The FSM, counter and output registers live in vga_pixel_stream.

## Test plan
Bench parameters: H_ACTIVE=4, V_ACTIVE=2, FIFO_DEPTH=4.
- Reset release, no stimulus -> RGB=0, s_ready=1, fifo_level=0, both flags 0.
- Stream 8 pixels 0x000001..0x000008, first beat with s_sof=1; pulse frame_start; de high 4 cycles, low 2, high 4 -> RGB shows 1..8 in order, one cycle after each de cycle; black elsewhere; no flags set.
- Send 3 non-sof beats, then an sof beat 0xFF0000 -> first 3 dropped, fifo_level=1, head is 0xFF0000.
- Stall renderer after 5 pixels while de continues -> 6th de cycle outputs 0, underflow=1, state RESYNC; flag clears at the next frame_start in ARMED.
- Insert a second s_sof on pixel 3 -> sync_err=1 the cycle after that pop; RGB black; recovery on the next sof frame.
- Assert rst mid-frame with fifo_level=3 -> RGB=0 and fifo_level=0 immediately (asynchronous); s_ready=1 in the first cycle after release.
